mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of one single-port memory.
// Each transaction takes ACCESS then DONE; ack pulses the cycle after.
module mem_port_arbiter #(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_LENGTH = 32,
  parameter int RR          = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0_req,
  input  logic                   m0_we,
  input  logic [ADDR_LENGTH-1:0] m0_addr,
  input  logic [DATA_LENGTH-1:0] m0_wdata,
  output logic                   m0_ack,
  output logic [DATA_LENGTH-1:0] m0_rdata,
  input  logic                   m1_req,
  input  logic                   m1_we,
  input  logic [ADDR_LENGTH-1:0] m1_addr,
  input  logic [DATA_LENGTH-1:0] m1_wdata,
  output logic                   m1_ack,
  output logic [DATA_LENGTH-1:0] m1_rdata,
  output logic [ADDR_LENGTH-1:0] mem_addr,
  output logic [DATA_LENGTH-1:0] mem_wdata,
  output logic                   mem_we,
  output logic                   mem_re,
  input  logic [DATA_LENGTH-1:0] mem_rdata,
  output logic                   busy,
  output logic                   grant_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic RR_EN = (RR != 0);

  state_t state;
  state_t state_nx;
  logic   gid;
  logic   gid_nx;
  logic   op_we;
  logic   op_we_nx;
  logic   elig0;
  logic   elig1;
  logic   win;
  logic   win_we;

  // A master is ignored in the cycle its own ack is showing.
  assign elig0 = m0_req & ~m0_ack;
  assign elig1 = m1_req & ~m1_ack;

  // Pick the winner among eligible masters.
  always_comb begin
    win = gid;
    unique case (1'b1)
      (elig0 & elig1):  win = RR_EN ? ~gid : 1'b0;
      (elig0 & ~elig1): win = 1'b0;
      (~elig0 & elig1): win = 1'b1;
      default:          win = gid;
    endcase
  end

  assign win_we = win ? m1_we : m0_we;

  // Next-state logic; winner and its operation latch on grant.
  always_comb begin
    state_nx = state;
    gid_nx   = gid;
    op_we_nx = op_we;
    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          state_nx = ACCESS;
          gid_nx   = win;
          op_we_nx = win_we;
        end
      end
      ACCESS:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, grant and latched operation registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gid   <= 1'b1;
      op_we <= 1'b0;
    end else begin
      state <= state_nx;
      gid   <= gid_nx;
      op_we <= op_we_nx;
    end
  end

  // Ack pulses the cycle after DONE, only for the winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
    end else begin
      m0_ack <= (state == DONE) & ~gid;
      m1_ack <= (state == DONE) & gid;
    end
  end

  // Read data captured in DONE into the winner's register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if ((state == DONE) && !op_we) begin
      if (gid) m1_rdata <= mem_rdata;
      else     m0_rdata <= mem_rdata;
    end
  end

  assign mem_addr  = gid ? m1_addr : m0_addr;
  assign mem_wdata = gid ? m1_wdata : m0_wdata;
  assign mem_we    = (state == ACCESS) & op_we;
  assign mem_re    = (state == ACCESS) & ~op_we;
  assign busy      = (state == ACCESS) | (state == DONE);
  assign grant_id  = gid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RR=1 (a_*) and RR=0 (b_*) instances
// share master stimulus; acks are checked against a scoreboard.
module tb_mem_port_arbiter;

  typedef struct {
    int          m;
    int          cyc;
    logic [31:0] rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0;
  logic        m0_we = 1'b0;
  logic [31:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic        m1_req = 1'b0;
  logic        m1_we = 1'b0;
  logic [31:0] m1_addr = '0;
  logic [31:0] m1_wdata = '0;

  logic        a_m0_ack, a_m1_ack, b_m0_ack, b_m1_ack;
  logic [31:0] a_m0_rdata, a_m1_rdata, b_m0_rdata, b_m1_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, b_mem_addr, b_mem_wdata;
  logic        a_mem_we, a_mem_re, b_mem_we, b_mem_re;
  logic [31:0] a_mem_rdata = '0;
  logic [31:0] b_mem_rdata = '0;
  logic        a_busy, a_grant, b_busy, b_grant;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          t0;
  logic [31:0] exp_rd [2];
  exp_t        qa [$];
  exp_t        qb [$];
  exp_t        ea;
  exp_t        eb;
  logic [1:0]  a_ack, b_ack;
  logic [31:0] a_rd [2];
  logic [31:0] b_rd [2];

  mem_port_arbiter #(.DATA_LENGTH(32), .ADDR_LENGTH(32), .RR(1)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_we(a_mem_we), .mem_re(a_mem_re), .mem_rdata(a_mem_rdata),
    .busy(a_busy), .grant_id(a_grant)
  );

  mem_port_arbiter #(.DATA_LENGTH(32), .ADDR_LENGTH(32), .RR(0)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_we(b_mem_we), .mem_re(b_mem_re), .mem_rdata(b_mem_rdata),
    .busy(b_busy), .grant_id(b_grant)
  );

  assign a_ack   = {a_m1_ack, a_m0_ack};
  assign b_ack   = {b_m1_ack, b_m0_ack};
  assign a_rd[0] = a_m0_rdata;
  assign a_rd[1] = a_m1_rdata;
  assign b_rd[0] = b_m0_rdata;
  assign b_rd[1] = b_m1_rdata;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h1001_0004) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic exp_t mk(input int m, input int c,
                              input logic [31:0] rd);
    exp_t e;
    e.m = m;
    e.cyc = c;
    e.rd = rd;
    return e;
  endfunction

  // Memory models: data one cycle after mem_re, junk otherwise.
  always @(posedge clk) begin
    a_mem_rdata <= a_mem_re ? memfn(a_mem_addr)
                            : (32'hBAD0_0000 | cyc[15:0]);
    b_mem_rdata <= b_mem_re ? memfn(b_mem_addr)
                            : (32'hBAD1_0000 | cyc[15:0]);
  end

  // Scoreboard: every ack must match the next expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        if (a_ack[m]) begin
          total++;
          if (qa.size() == 0) begin
            bad++;
            $display("FAIL a_ack_extra m%0d cyc=%0d got=1 want=0",
                     m, cyc);
          end else begin
            ea = qa.pop_front();
            if (ea.m != m || ea.cyc != cyc || a_rd[m] !== ea.rd) begin
              bad++;
              $display("FAIL a_ack got m%0d c%0d rd=%h want m%0d c%0d rd=%h",
                       m, cyc, a_rd[m], ea.m, ea.cyc, ea.rd);
            end
          end
        end
        if (b_ack[m]) begin
          total++;
          if (qb.size() == 0) begin
            bad++;
            $display("FAIL b_ack_extra m%0d cyc=%0d got=1 want=0",
                     m, cyc);
          end else begin
            eb = qb.pop_front();
            if (eb.m != m || eb.cyc != cyc || b_rd[m] !== eb.rd) begin
              bad++;
              $display("FAIL b_ack got m%0d c%0d rd=%h want m%0d c%0d rd=%h",
                       m, cyc, b_rd[m], eb.m, eb.cyc, eb.rd);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (a_busy !== 1'b0 || a_grant !== 1'b1 || a_ack !== 2'b00) begin
      bad++;
      $display("FAIL reset_a_ctl busy=%b grant=%b ack=%b want 0 1 00",
               a_busy, a_grant, a_ack);
    end
    total++;
    if (a_mem_we !== 1'b0 || a_mem_re !== 1'b0) begin
      bad++;
      $display("FAIL reset_a_mem we=%b re=%b want 0 0",
               a_mem_we, a_mem_re);
    end
    total++;
    if (a_m0_rdata !== 32'h0 || a_m1_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_a_rdata %h %h want 0 0",
               a_m0_rdata, a_m1_rdata);
    end
    total++;
    if (b_busy !== 1'b0 || b_grant !== 1'b1 || b_ack !== 2'b00 ||
        b_mem_we !== 1'b0 || b_mem_re !== 1'b0) begin
      bad++;
      $display("FAIL reset_b busy=%b grant=%b ack=%b we=%b re=%b",
               b_busy, b_grant, b_ack, b_mem_we, b_mem_re);
    end
    step();
    rst = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic test_single(input int m, input logic we,
                             input logic [31:0] addr,
                             input logic [31:0] wd);
    exp_t e;
    step();
    t0 = cyc;
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
    end
    if (!we) exp_rd[m] = memfn(addr);
    e = mk(m, t0 + 3, exp_rd[m]);
    qa.push_back(e);
    qb.push_back(e);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (a_mem_re !== (k == 1 && !we) ||
          a_mem_we !== (k == 1 && we)) begin
        bad++;
        $display("FAIL single_strobe k=%0d re=%b we=%b op_we=%b",
                 k, a_mem_re, a_mem_we, we);
      end
      total++;
      if (a_busy !== (k == 1 || k == 2) ||
          b_busy !== (k == 1 || k == 2)) begin
        bad++;
        $display("FAIL single_busy k=%0d a=%b b=%b", k, a_busy, b_busy);
      end
      if (k == 1) begin
        total++;
        if (a_mem_addr !== addr || (we && a_mem_wdata !== wd) ||
            a_grant !== logic'(m)) begin
          bad++;
          $display("FAIL single_bus addr=%h wd=%h g=%b want %h %h %0d",
                   a_mem_addr, a_mem_wdata, a_grant, addr, wd, m);
        end
      end
      step();
      if (k == 3) begin
        if (m == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
      end
    end
    total++;
    if (a_rd[1-m] !== exp_rd[1-m] || b_rd[1-m] !== exp_rd[1-m]) begin
      bad++;
      $display("FAIL single_other_rdata a=%h b=%h want %h",
               a_rd[1-m], b_rd[1-m], exp_rd[1-m]);
    end
  endtask

  task automatic test_rr_vs_fixed();
    logic [31:0] x;
    logic [31:0] y;
    x = 32'h0000_0100;
    y = 32'h0000_0200;
    step();
    t0 = cyc;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = x;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = y;
    exp_rd[0] = memfn(x);
    exp_rd[1] = memfn(y);
    qa.push_back(mk(1, t0 + 3, exp_rd[1]));
    qa.push_back(mk(0, t0 + 6, exp_rd[0]));
    qb.push_back(mk(0, t0 + 3, exp_rd[0]));
    qb.push_back(mk(1, t0 + 6, exp_rd[1]));
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 1 || k == 4) begin
        total++;
        if (a_grant !== (k == 1) || b_grant !== (k == 4)) begin
          bad++;
          $display("FAIL rr_vs_fixed_grant k=%0d a=%b b=%b", k,
                   a_grant, b_grant);
        end
      end
      step();
      if (k == 3) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
  endtask

  task automatic test_rr_contention();
    logic [31:0] p;
    logic [31:0] q;
    p = 32'h0000_0A00;
    q = 32'h0000_0B00;
    do_reset();
    step();
    t0 = cyc;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = p;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = q;
    exp_rd[0] = memfn(p);
    exp_rd[1] = memfn(q);
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mk(i % 2, t0 + 3 * (i + 1), exp_rd[i % 2]));
      qb.push_back(mk(i % 2, t0 + 3 * (i + 1), exp_rd[i % 2]));
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 1 || k == 4 || k == 7 || k == 10) begin
        total++;
        if (a_grant !== (k == 4 || k == 10)) begin
          bad++;
          $display("FAIL rr_grant_seq k=%0d got=%b want=%b", k,
                   a_grant, (k == 4 || k == 10));
        end
      end
      step();
      if (k == 9)  m0_req = 1'b0;
      if (k == 12) m1_req = 1'b0;
    end
  endtask

  task automatic test_fixed_contention();
    do_reset();
    step();
    t0 = cyc;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0C00;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0D00;
    exp_rd[0] = memfn(32'h0000_0C00);
    exp_rd[1] = memfn(32'h0000_0D00);
    qa.push_back(mk(0, t0 + 3, exp_rd[0]));
    qa.push_back(mk(1, t0 + 6, exp_rd[1]));
    qb.push_back(mk(0, t0 + 3, exp_rd[0]));
    qb.push_back(mk(1, t0 + 6, exp_rd[1]));
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++;
        if (b_grant !== 1'b0) begin
          bad++;
          $display("FAIL fixed_first got=%b want=0", b_grant);
        end
      end
      if (k == 3) begin
        total++;
        if (b_grant !== 1'b0 || b_m0_ack !== 1'b1 || b_busy !== 1'b0) begin
          bad++;
          $display("FAIL fixed_c3 g=%b ack0=%b busy=%b want 0 1 0",
                   b_grant, b_m0_ack, b_busy);
        end
      end
      if (k == 4) begin
        total++;
        if (b_grant !== 1'b1 || b_busy !== 1'b1) begin
          bad++;
          $display("FAIL fixed_c4 g=%b busy=%b want 1 1",
                   b_grant, b_busy);
        end
      end
      step();
      if (k == 3) m0_req = 1'b0;
      if (k == 6) m1_req = 1'b0;
    end
  endtask

  task automatic test_reset_access();
    step();
    t0 = cyc;
    m0_req = 1'b1; m0_we = 1'b1;
    m0_addr = 32'h0000_0E00; m0_wdata = 32'h1234_5678;
    @(negedge clk);
    step();
    @(negedge clk);
    total++;
    if (a_mem_we !== 1'b1 || a_grant !== 1'b0) begin
      bad++;
      $display("FAIL rst_acc_pre we=%b g=%b want 1 0", a_mem_we, a_grant);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (a_mem_we !== 1'b0 || a_busy !== 1'b0 || a_grant !== 1'b1 ||
        b_mem_we !== 1'b0 || b_busy !== 1'b0 || b_grant !== 1'b1) begin
      bad++;
      $display("FAIL rst_acc_async a=%b%b%b b=%b%b%b want 001 001",
               a_mem_we, a_busy, a_grant, b_mem_we, b_busy, b_grant);
    end
    total++;
    if (a_m0_rdata !== 32'h0 || a_ack !== 2'b00) begin
      bad++;
      $display("FAIL rst_acc_regs rd=%h ack=%b want 0 00",
               a_m0_rdata, a_ack);
    end
    step();
    step();
    rst = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    t0 = cyc;
    qa.push_back(mk(0, t0 + 3, exp_rd[0]));
    qb.push_back(mk(0, t0 + 3, exp_rd[0]));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++;
        if (a_mem_we !== 1'b1 || a_mem_wdata !== 32'h1234_5678) begin
          bad++;
          $display("FAIL rst_acc_retry we=%b wd=%h want 1 12345678",
                   a_mem_we, a_mem_wdata);
        end
      end
      step();
      if (k == 3) m0_req = 1'b0;
    end
  endtask

  task automatic test_protocol();
    step();
    t0 = cyc;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0F00;
    exp_rd[0] = memfn(32'h0000_0F00);
    qa.push_back(mk(0, t0 + 3, exp_rd[0]));
    qb.push_back(mk(0, t0 + 3, exp_rd[0]));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++;
        if (a_mem_re !== 1'b1 || a_busy !== 1'b1) begin
          bad++;
          $display("FAIL proto_access re=%b busy=%b want 1 1",
                   a_mem_re, a_busy);
        end
      end
      if (k == 3 || k == 4) begin
        total++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
          bad++;
          $display("FAIL proto_idle k=%0d a=%b b=%b want 0 0",
                   k, a_busy, b_busy);
        end
      end
      step();
      if (k == 0) m0_req = 1'b0;
    end
  endtask

  initial begin
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    test_reset();
    test_single(0, 1'b0, 32'h1001_0004, 32'h0);
    test_rr_vs_fixed();
    test_single(1, 1'b0, 32'h2000_0010, 32'h0);
    test_single(1, 1'b1, 32'h1001_0000, 32'h0000_0055);
    test_rr_contention();
    test_fixed_contention();
    test_reset_access();
    test_protocol();
    step();
    step();
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL missing_acks a=%0d b=%0d want 0 0",
               qa.size(), qb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
